decode_stage: RTL and testbench

Registered, parametrised RV32I/RV64I instruction decode stage with a valid/ready handshake on both sides. It takes a fetched instruction word and its PC from fetch, and presents a registered decoded bundle to execute. The bundle carries the opcode class, register indices, function fields, the format-selected sign-extended immediate, operand-use flags and an illegal-instruction flag. A two-entry skid buffer gives full throughput under backpressure, and a synchronous flush supports branch redirect.

---
 rtl/decode_stage.sv | 260 ++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational field/immediate decode feeding a registered
// output bundle backed by one skid entry, so upstream sees a registered in_ready.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_class,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rd_we,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [3:0] CLS_LUI      = 4'd0;
    localparam logic [3:0] CLS_AUIPC    = 4'd1;
    localparam logic [3:0] CLS_JAL      = 4'd2;
    localparam logic [3:0] CLS_JALR     = 4'd3;
    localparam logic [3:0] CLS_BRANCH   = 4'd4;
    localparam logic [3:0] CLS_LOAD     = 4'd5;
    localparam logic [3:0] CLS_STORE    = 4'd6;
    localparam logic [3:0] CLS_OPIMM    = 4'd7;
    localparam logic [3:0] CLS_OP       = 4'd8;
    localparam logic [3:0] CLS_MISC_MEM = 4'd9;
    localparam logic [3:0] CLS_SYSTEM   = 4'd10;
    localparam logic [3:0] CLS_ILLEGAL  = 4'd15;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      cls;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            rs1_used;
        logic            rs2_used;
        logic            illegal;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Signed raw immediates; a signed size cast sign-extends them to XLEN.
    logic signed [11:0] imm_i_raw;
    logic signed [11:0] imm_s_raw;
    logic signed [12:0] imm_b_raw;
    logic signed [31:0] imm_u_raw;
    logic signed [20:0] imm_j_raw;

    assign imm_i_raw = in_instr[31:20];
    assign imm_s_raw = {in_instr[31:25], in_instr[11:7]};
    assign imm_b_raw = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u_raw = {in_instr[31:12], 12'b0};
    assign imm_j_raw = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic slli_bad;
    logic srxi_bad;
    logic load_bad;
    logic store_bad;

    generate
        if (XLEN == 64) begin : g_rv64
            assign slli_bad  = |in_instr[31:26];
            assign srxi_bad  = (in_instr[31:26] != 6'b000000) && (in_instr[31:26] != 6'b010000);
            assign load_bad  = (funct3 == 3'd7);
            assign store_bad = (funct3 > 3'd3);
        end else begin : g_rv32
            assign slli_bad  = |in_instr[31:25];
            assign srxi_bad  = (in_instr[31:25] != 7'b0000000) && (in_instr[31:25] != 7'b0100000);
            assign load_bad  = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
            assign store_bad = (funct3 > 3'd2);
        end
    endgenerate

    bundle_t dec_next;
    logic    legal;
    logic    writes_rd;

    always_comb begin
        dec_next        = '0;
        dec_next.pc     = in_pc;
        dec_next.rd     = in_instr[11:7];
        dec_next.rs1    = in_instr[19:15];
        dec_next.rs2    = in_instr[24:20];
        dec_next.funct3 = funct3;
        dec_next.funct7 = funct7;
        dec_next.cls    = CLS_ILLEGAL;
        legal           = 1'b1;
        writes_rd       = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_next.cls = CLS_LUI;
                dec_next.imm = XLEN'(imm_u_raw);
                writes_rd    = 1'b1;
            end
            OPC_AUIPC: begin
                dec_next.cls = CLS_AUIPC;
                dec_next.imm = XLEN'(imm_u_raw);
                writes_rd    = 1'b1;
            end
            OPC_JAL: begin
                dec_next.cls = CLS_JAL;
                dec_next.imm = XLEN'(imm_j_raw);
                writes_rd    = 1'b1;
            end
            OPC_JALR: begin
                dec_next.cls      = CLS_JALR;
                dec_next.imm      = XLEN'(imm_i_raw);
                dec_next.rs1_used = 1'b1;
                writes_rd         = 1'b1;
                legal             = (funct3 == 3'd0);
            end
            OPC_BRANCH: begin
                dec_next.cls      = CLS_BRANCH;
                dec_next.imm      = XLEN'(imm_b_raw);
                dec_next.rs1_used = 1'b1;
                dec_next.rs2_used = 1'b1;
                legal             = (funct3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                dec_next.cls      = CLS_LOAD;
                dec_next.imm      = XLEN'(imm_i_raw);
                dec_next.rs1_used = 1'b1;
                writes_rd         = 1'b1;
                legal             = !load_bad;
            end
            OPC_STORE: begin
                dec_next.cls      = CLS_STORE;
                dec_next.imm      = XLEN'(imm_s_raw);
                dec_next.rs1_used = 1'b1;
                dec_next.rs2_used = 1'b1;
                legal             = !store_bad;
            end
            OPC_OPIMM: begin
                dec_next.cls      = CLS_OPIMM;
                dec_next.imm      = XLEN'(imm_i_raw);
                dec_next.rs1_used = 1'b1;
                writes_rd         = 1'b1;
                legal             = !((funct3 == 3'd1 && slli_bad) || (funct3 == 3'd5 && srxi_bad));
            end
            OPC_OP: begin
                dec_next.cls      = CLS_OP;
                dec_next.rs1_used = 1'b1;
                dec_next.rs2_used = 1'b1;
                writes_rd         = 1'b1;
                legal             = (funct7 == 7'h00) ||
                                    (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
            end
            OPC_MISC_MEM: begin
                dec_next.cls = CLS_MISC_MEM;
            end
            OPC_SYSTEM: begin
                dec_next.cls = CLS_SYSTEM;
                dec_next.imm = XLEN'(imm_i_raw);
                writes_rd    = (funct3 != 3'd0);
            end
            default: legal = 1'b0;
        endcase
        dec_next.rd_we = writes_rd && (in_instr[11:7] != 5'd0);
        // Raw register/funct fields are kept on illegal bundles for trap reporting.
        if (!legal || in_instr[1:0] != 2'b11) begin
            dec_next.cls      = CLS_ILLEGAL;
            dec_next.imm      = '0;
            dec_next.rd_we    = 1'b0;
            dec_next.rs1_used = 1'b0;
            dec_next.rs2_used = 1'b0;
            dec_next.illegal  = 1'b1;
        end
    end

    bundle_t main_reg;
    bundle_t skid_reg;
    logic    main_valid_reg;
    logic    skid_valid_reg;
    logic    in_ready_reg;
    logic    accept;

    assign accept = in_valid && in_ready_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else if (!main_valid_reg || out_ready) begin
            // Main slot frees up this cycle: refill from skid first to keep FIFO order.
            if (skid_valid_reg) begin
                main_reg       <= skid_reg;
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
                in_ready_reg   <= 1'b1;
            end else begin
                main_valid_reg <= accept;
                if (accept) begin
                    main_reg <= dec_next;
                end
            end
        end else if (accept) begin
            skid_reg       <= dec_next;
            skid_valid_reg <= 1'b1;
            in_ready_reg   <= 1'b0;
        end
    end

    assign in_ready     = in_ready_reg;
    assign out_valid    = main_valid_reg;
    assign out_pc       = main_reg.pc;
    assign out_class    = main_reg.cls;
    assign out_rd       = main_reg.rd;
    assign out_rs1      = main_reg.rs1;
    assign out_rs2      = main_reg.rs2;
    assign out_funct3   = main_reg.funct3;
    assign out_funct7   = main_reg.funct7;
    assign out_imm      = main_reg.imm;
    assign out_rd_we    = main_reg.rd_we;
    assign out_rs1_used = main_reg.rs1_used;
    assign out_rs2_used = main_reg.rs2_used;
    assign out_illegal  = main_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an XLEN=32 instance (a_*) and an XLEN=64 instance (b_*),
// checked against a queue of bundles decoded by an arithmetic reference model.
module tb_decode_stage;

    logic        clk;
    logic        rst_a, rst_b, a_flush, b_flush;
    logic        a_in_valid, b_in_valid, a_in_ready, b_in_ready;
    logic        a_out_valid, b_out_valid, a_out_ready, b_out_ready;
    logic [31:0] a_in_instr, b_in_instr, a_in_pc, a_out_pc, a_out_imm;
    logic [63:0] b_in_pc, b_out_pc, b_out_imm;
    logic [3:0]  a_out_class, b_out_class;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2, b_out_rd, b_out_rs1, b_out_rs2;
    logic [2:0]  a_out_funct3, b_out_funct3;
    logic [6:0]  a_out_funct7, b_out_funct7;
    logic        a_out_rd_we, a_out_rs1_used, a_out_rs2_used, a_out_illegal;
    logic        b_out_rd_we, b_out_rs1_used, b_out_rs2_used, b_out_illegal;

    decode_stage #(.XLEN(32)) dut_a (
        .clk(clk), .rst(rst_a), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_pc(a_in_pc), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pc(a_out_pc), .out_class(a_out_class), .out_rd(a_out_rd), .out_rs1(a_out_rs1),
        .out_rs2(a_out_rs2), .out_funct3(a_out_funct3), .out_funct7(a_out_funct7),
        .out_imm(a_out_imm), .out_rd_we(a_out_rd_we), .out_rs1_used(a_out_rs1_used),
        .out_rs2_used(a_out_rs2_used), .out_illegal(a_out_illegal)
    );

    decode_stage #(.XLEN(64)) dut_b (
        .clk(clk), .rst(rst_b), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(b_in_pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_class(b_out_class), .out_rd(b_out_rd), .out_rs1(b_out_rs1),
        .out_rs2(b_out_rs2), .out_funct3(b_out_funct3), .out_funct7(b_out_funct7),
        .out_imm(b_out_imm), .out_rd_we(b_out_rd_we), .out_rs1_used(b_out_rs1_used),
        .out_rs2_used(b_out_rs2_used), .out_illegal(b_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundles, widened to a common 161-bit layout.
    logic [160:0] obs_a, obs_b;
    assign obs_a = {32'b0, a_out_pc, a_out_class, a_out_rd, a_out_rs1, a_out_rs2, a_out_funct3,
                    a_out_funct7, 32'b0, a_out_imm, a_out_rd_we, a_out_rs1_used, a_out_rs2_used,
                    a_out_illegal};
    assign obs_b = {b_out_pc, b_out_class, b_out_rd, b_out_rs1, b_out_rs2, b_out_funct3,
                    b_out_funct7, b_out_imm, b_out_rd_we, b_out_rs1_used, b_out_rs2_used,
                    b_out_illegal};

    int           checks = 0;
    int           errors = 0;
    logic [160:0] qa[$];
    logic [160:0] qb[$];
    logic [31:0]  pc_a = 32'h0000_1000;
    logic [63:0]  pc_b = 64'hFFFF_FFFF_0000_1000;
    int           acc_cnt_a = 0;
    int           acc_cnt_b = 0;

    function automatic logic [160:0] ref_bundle(input int xlen, input logic [31:0] ins,
                                                input logic [63:0] pc);
        int     op, f3, f7, cls, up, alt;
        longint imm;
        bit     ill, we, u1, u2;
        op  = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        ill = (ins[1:0] != 2'b11);
        cls = 15;
        imm = 0;
        case (op)
            'h37: cls = 0;
            'h17: cls = 1;
            'h6F: cls = 2;
            'h67: cls = 3;
            'h63: cls = 4;
            'h03: cls = 5;
            'h23: cls = 6;
            'h13: cls = 7;
            'h33: cls = 8;
            'h0F: cls = 9;
            'h73: cls = 10;
            default: ill = 1;
        endcase
        if (cls inside {3, 5, 7, 10}) begin
            imm = ins[31:20];
            if (imm >= 2048) imm -= 4096;
        end else if (cls == 6) begin
            imm = ins[31:25] * 32 + ins[11:7];
            if (imm >= 2048) imm -= 4096;
        end else if (cls == 4) begin
            imm = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
            if (imm >= 4096) imm -= 8192;
        end else if (cls inside {0, 1}) begin
            imm = longint'(ins[31:12]) * 4096;
            if (ins[31]) imm -= 64'h1_0000_0000;
        end else if (cls == 2) begin
            imm = ins[31] * (2 ** 20) + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
            if (imm >= 2 ** 20) imm -= 2 ** 21;
        end
        case (cls)
            3: if (f3 != 0) ill = 1;
            4: if (f3 inside {2, 3}) ill = 1;
            5: if ((xlen == 32) ? (f3 inside {3, 6, 7}) : (f3 == 7)) ill = 1;
            6: if (f3 > ((xlen == 32) ? 2 : 3)) ill = 1;
            8: if (!(f7 == 0 || (f7 == 'h20 && (f3 inside {0, 5})))) ill = 1;
            7: begin
                up  = (xlen == 32) ? int'(ins[31:25]) : int'(ins[31:26]);
                alt = (xlen == 32) ? 'h20 : 'h10;
                if (f3 == 1 && up != 0) ill = 1;
                if (f3 == 5 && up != 0 && up != alt) ill = 1;
            end
            default: ;
        endcase
        we = ((cls inside {0, 1, 2, 3, 5, 7, 8}) || (cls == 10 && f3 != 0)) && (ins[11:7] != 0);
        u1 = cls inside {3, 4, 5, 6, 7, 8};
        u2 = cls inside {4, 6, 8};
        if (ill) begin
            cls = 15; imm = 0; we = 0; u1 = 0; u2 = 0;
        end
        if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
        return {pc, 4'(cls), ins[11:7], ins[19:15], ins[24:20], ins[14:12], ins[31:25],
                64'(imm), we, u1, u2, ill};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 12))
            0: ins[6:0] = 7'h37;   1: ins[6:0] = 7'h17;   2: ins[6:0] = 7'h6F;
            3: ins[6:0] = 7'h67;   4: ins[6:0] = 7'h63;   5: ins[6:0] = 7'h03;
            6: ins[6:0] = 7'h23;   7: ins[6:0] = 7'h13;   8: ins[6:0] = 7'h33;
            9: ins[6:0] = 7'h0F;  10: ins[6:0] = 7'h73;  11: ins[6:0] = 7'h1B;
            default: ;
        endcase
        case ($urandom_range(0, 4))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            2: ins[31:25] = 7'h21;
            3: ins[31:25] = 7'h01;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    // Drives one cycle starting at a negedge, updates the model queues, returns at the next negedge.
    task automatic drive(input bit use_a, input bit use_b, input bit v, input logic [31:0] ins,
                         input bit rdy, input bit fl);
        bit acc_a, cons_a, acc_b, cons_b;
        a_in_valid = use_a & v;  a_in_instr = ins;  a_in_pc = pc_a;
        a_out_ready = use_a ? rdy : 1'b1;  a_flush = use_a & fl;
        b_in_valid = use_b & v;  b_in_instr = ins;  b_in_pc = pc_b;
        b_out_ready = use_b ? rdy : 1'b1;  b_flush = use_b & fl;
        acc_a  = a_in_valid && a_in_ready;
        cons_a = a_out_valid && a_out_ready;
        acc_b  = b_in_valid && b_in_ready;
        cons_b = b_out_valid && b_out_ready;
        @(posedge clk);
        if (a_flush) qa.delete();
        else begin
            if (cons_a && qa.size() > 0) qa.delete(0);
            if (acc_a) begin
                qa.push_back(ref_bundle(32, ins, {32'b0, pc_a}));
                pc_a += 4;
                acc_cnt_a++;
            end
        end
        if (b_flush) qb.delete();
        else begin
            if (cons_b && qb.size() > 0) qb.delete(0);
            if (acc_b) begin
                qb.push_back(ref_bundle(64, ins, pc_b));
                pc_b += 4;
                acc_cnt_b++;
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0;  b_in_valid = 1'b0;  a_flush = 1'b0;  b_flush = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready: got %b expected 1", a_in_ready); end
        checks++; if (obs_a !== '0) begin errors++; $display("FAIL reset_a_payload: got %h expected 0", obs_a); end
        checks++; if (obs_b !== '0) begin errors++; $display("FAIL reset_b_payload: got %h expected 0", obs_b); end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_b_out_valid: got %b expected 0", b_out_valid); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_b_in_ready: got %b expected 1", b_in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_addi();
        drive(1, 0, 1, 32'h0050_0093, 1, 0);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b expected 1", a_out_valid); end
        checks++; if (a_out_class !== 4'd7) begin errors++; $display("FAIL addi_class: got %0d expected 7", a_out_class); end
        checks++; if (a_out_rd !== 5'd1 || a_out_rs1 !== 5'd0) begin errors++; $display("FAIL addi_regs: got rd=%0d rs1=%0d expected rd=1 rs1=0", a_out_rd, a_out_rs1); end
        checks++; if (a_out_imm !== 32'h5) begin errors++; $display("FAIL addi_imm: got %h expected 00000005", a_out_imm); end
        checks++; if ({a_out_rd_we, a_out_rs1_used, a_out_rs2_used, a_out_illegal} !== 4'b1100) begin errors++; $display("FAIL addi_flags: got %b expected 1100", {a_out_rd_we, a_out_rs1_used, a_out_rs2_used, a_out_illegal}); end
        drive(1, 1, 0, 32'h0, 1, 0);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b expected 0", a_out_valid); end
        $display("test_addi done");
    endtask

    task automatic test_branch_lui();
        drive(1, 0, 1, 32'hFE00_0EE3, 1, 0);
        checks++; if (a_out_class !== 4'd4) begin errors++; $display("FAIL beq_class: got %0d expected 4", a_out_class); end
        checks++; if (a_out_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_imm: got %h expected fffffffc", a_out_imm); end
        checks++; if (a_out_rd_we !== 1'b0 || a_out_rs2_used !== 1'b1) begin errors++; $display("FAIL beq_flags: got rd_we=%b rs2_used=%b expected 0 1", a_out_rd_we, a_out_rs2_used); end
        drive(1, 0, 1, 32'h1234_50B7, 1, 0);
        checks++; if (a_out_class !== 4'd0 || a_out_rd !== 5'd1) begin errors++; $display("FAIL lui_class_rd: got %0d/%0d expected 0/1", a_out_class, a_out_rd); end
        checks++; if (a_out_imm !== 32'h1234_5000) begin errors++; $display("FAIL lui_imm: got %h expected 12345000", a_out_imm); end
        checks++; if (qa.size() == 0 || obs_a !== qa[0]) begin errors++; $display("FAIL lui_bundle: got %h expected %h", obs_a, (qa.size() > 0) ? qa[0] : '0); end
        drive(1, 1, 0, 32'h0, 1, 0);
        $display("test_branch_lui done");
    endtask

    task automatic test_illegal();
        logic [31:0] pc2;
        drive(1, 0, 1, 32'h0000_0000, 1, 0);
        checks++; if ({a_out_illegal, a_out_class, a_out_rd_we} !== {1'b1, 4'd15, 1'b0}) begin errors++; $display("FAIL illegal_zero: got ill=%b cls=%0d we=%b expected 1 15 0", a_out_illegal, a_out_class, a_out_rd_we); end
        pc2 = pc_a;
        drive(1, 0, 1, 32'h4000_1033, 1, 0);
        checks++; if ({a_out_illegal, a_out_class, a_out_rd_we} !== {1'b1, 4'd15, 1'b0}) begin errors++; $display("FAIL illegal_op: got ill=%b cls=%0d we=%b expected 1 15 0", a_out_illegal, a_out_class, a_out_rd_we); end
        checks++; if (a_out_pc !== pc2) begin errors++; $display("FAIL illegal_order: got pc %h expected %h", a_out_pc, pc2); end
        drive(1, 1, 0, 32'h0, 1, 0);
        $display("test_illegal done");
    endtask

    task automatic test_backpressure();
        logic [31:0]  ins[4];
        logic [160:0] first;
        logic [160:0] seen[$];
        logic [31:0]  pc0;
        int           idx, acc0;
        for (int i = 0; i < 4; i++) ins[i] = 32'h0000_0093 | (32'(i + 1) << 20) | (32'(i + 1) << 7);
        pc0   = pc_a;
        acc0  = acc_cnt_a;
        idx   = 0;
        first = ref_bundle(32, ins[0], {32'b0, pc0});
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 1, ins[idx], 0, 0);
            idx = acc_cnt_a - acc0;
            checks++; if (a_out_valid !== 1'b1 || obs_a !== first) begin errors++; $display("FAIL bp_hold_c%0d: got v=%b %h expected v=1 %h", c, a_out_valid, obs_a, first); end
        end
        checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", a_in_ready); end
        for (int c = 0; c < 5; c++) begin
            if (a_out_valid) seen.push_back(obs_a);
            drive(1, 0, idx < 3, ins[idx], 1, 0);
            idx = acc_cnt_a - acc0;
        end
        checks++; if (seen.size() !== 3) begin errors++; $display("FAIL bp_drain_count: got %0d expected 3", seen.size()); end
        for (int k = 0; k < 3 && k < seen.size(); k++) begin
            checks++; if (seen[k] !== ref_bundle(32, ins[k], {32'b0, pc0 + 32'(4 * k)})) begin errors++; $display("FAIL bp_drain_order_%0d: got %h expected %h", k, seen[k], ref_bundle(32, ins[k], {32'b0, pc0 + 32'(4 * k)})); end
        end
        checks++; if (idx !== 3 || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: got accepted=%0d in_ready=%b expected 3 1", idx, a_in_ready); end
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        drive(1, 0, 1, 32'h0010_0113, 0, 0);
        drive(1, 0, 1, 32'h0020_0193, 0, 0);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_full: got in_ready %b expected 0", a_in_ready); end
        drive(1, 0, 1, 32'h0030_0213, 0, 1);
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got v=%b rdy=%b expected 0 1", a_out_valid, a_in_ready); end
        // One held entry leaves in_ready high, so the flush-cycle input really handshakes.
        drive(1, 0, 1, 32'h0040_0293, 0, 0);
        drive(1, 0, 1, 32'h0050_0313, 0, 1);
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 0, 32'h0, 1, 0);
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak_c%0d: got out_valid %b pc %h expected 0", c, a_out_valid, a_out_pc); end
        end
        $display("test_flush done");
    endtask

    task automatic test_random();
        logic [31:0] cur;
        int          last_acc;
        bit          v, rdy, fl;
        cur      = rand_instr();
        last_acc = acc_cnt_a;
        for (int c = 0; c < 1500; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            drive(1, 1, v, cur, rdy, fl);
            if (acc_cnt_a != last_acc || fl) cur = rand_instr();
            last_acc = acc_cnt_a;
            checks++; if (a_out_valid !== (qa.size() > 0) || a_in_ready !== (qa.size() < 2)) begin errors++; $display("FAIL rand_a_flow_c%0d: got v=%b rdy=%b held=%0d", c, a_out_valid, a_in_ready, qa.size()); end
            checks++; if (b_out_valid !== (qb.size() > 0) || b_in_ready !== (qb.size() < 2)) begin errors++; $display("FAIL rand_b_flow_c%0d: got v=%b rdy=%b held=%0d", c, b_out_valid, b_in_ready, qb.size()); end
            if (qa.size() > 0) begin
                checks++; if (obs_a !== qa[0]) begin errors++; $display("FAIL rand_a_bundle_c%0d: got %h expected %h", c, obs_a, qa[0]); end
            end
            if (qb.size() > 0) begin
                checks++; if (obs_b !== qb[0]) begin errors++; $display("FAIL rand_b_bundle_c%0d: got %h expected %h", c, obs_b, qb[0]); end
            end
        end
        repeat (3) drive(1, 1, 0, 32'h0, 1, 0);
        $display("test_random done");
    endtask

    task automatic test_async_reset64();
        drive(0, 1, 1, 32'h0050_0093, 0, 0);
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", b_out_valid); end
        #2 rst_b = 1'b1;
        #1;
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL ar_clear_flow: got v=%b rdy=%b expected 0 1", b_out_valid, b_in_ready); end
        checks++; if (obs_b !== '0) begin errors++; $display("FAIL ar_clear_payload: got %h expected 0", obs_b); end
        qb.delete();
        @(negedge clk);
        rst_b = 1'b0;
        drive(0, 1, 1, 32'h4030_D093, 1, 0);
        checks++; if (b_out_class !== 4'd7 || b_out_funct7 !== 7'h20 || b_out_illegal !== 1'b0) begin errors++; $display("FAIL srai_fields: got cls=%0d f7=%h ill=%b expected 7 20 0", b_out_class, b_out_funct7, b_out_illegal); end
        // instr[31] is 0 here, so the I-immediate 0x403 stays positive.
        checks++; if (b_out_imm !== 64'h0000_0000_0000_0403) begin errors++; $display("FAIL srai_imm: got %h expected 0000000000000403", b_out_imm); end
        checks++; if (qb.size() == 0 || obs_b !== qb[0]) begin errors++; $display("FAIL srai_bundle: got %h expected %h", obs_b, (qb.size() > 0) ? qb[0] : '0); end
        drive(1, 1, 0, 32'h0, 1, 0);
        $display("test_async_reset64 done");
    endtask

    initial begin
        rst_a = 1'b1;  rst_b = 1'b1;
        a_flush = 1'b0;  b_flush = 1'b0;
        a_in_valid = 1'b0;  b_in_valid = 1'b0;
        a_out_ready = 1'b1;  b_out_ready = 1'b1;
        a_in_instr = '0;  b_in_instr = '0;
        a_in_pc = '0;  b_in_pc = '0;
        test_reset();
        test_addi();
        test_branch_lui();
        test_illegal();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
